load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the MEM pipeline stage and the word-addressed data memory: accepts one load/store request at a time and issues word accesses to memory.
- Converts RISC-V byte addresses and funct3 sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) into word-index accesses.
- Performs read-modify-write for sub-word stores and lane extraction plus sign/zero extension for loads.
- Flags misaligned and illegal accesses without touching memory.

Parameters:
- ADDR_W, 32: width of request byte address and memory address port.
- MEM_WORDS, 256: number of 32-bit words in data memory; used by the optional bounds check.

Ports:
- clk  in  1  rising-edge clock shared with data memory.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit idle; a request is accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (size/sign).
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_valid; 1 = misaligned, illegal funct3, or out of range.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_addr  out  ADDR_W  word index = {2'b00, addr[ADDR_W-1:2]}.
- mem_wdata  out  32  word written to memory.
- mem_re  out  1  memory read enable; data is visible on mem_rdata the cycle after.
- mem_we  out  1  memory write enable; memory commits at the rising edge.
- mem_rdata  in  32  memory read data (registered inside memory).

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; req_ready=1.
  - resp_valid=0, resp_err=0, resp_rdata=0.
  - mem_re=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Internal request and merge registers cleared.
- States: IDLE, READ, CAPTURE, MERGE, WRITE.
  - All mem_* outputs and req_ready are Moore outputs of the state and the registered request.
  - resp_* are registered.
- IDLE:
  - req_ready=1. On accept, capture we/funct3/addr/wdata.
  - Error on: illegal funct3 (load 011/110/111; store anything but 000/001/010); half with addr[0]=1; word with addr[1:0]!=0.
  - Error: stay IDLE, pulse resp_valid=1 and resp_err=1 next cycle. No mem_re or mem_we is ever driven.
  - Legal load or sub-word store goes to READ; SW goes to WRITE.
- READ: mem_re=1, mem_addr=word index. Next state: CAPTURE for loads, MERGE for stores.
- CAPTURE:
  - Select the lane from mem_rdata by addr[1:0] (byte) or addr[1] (half).
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into resp_rdata, go to IDLE, and pulse resp_valid with resp_err=0.
- MERGE:
  - Replace the byte lane addr[1:0] (SB) or half lane addr[1] (SH) of mem_rdata with req_wdata[7:0] or [15:0].
  - Register the merged word into mem_wdata, then go to WRITE.
- WRITE: mem_we=1. mem_wdata is req_wdata for SW, otherwise the merged word. Go to IDLE and pulse resp_valid.
- Latency, cycle 0 = accept, resp_valid high in cycle:
  - Error: 1.
  - SW: 2.
  - Load: 3.
  - SB/SH: 4.
- resp_valid is high for exactly one cycle. It coincides with req_ready=1, so back-to-back accepts are legal in that cycle.
- mem_re and mem_we are never high together; each is high for at most one cycle per request.
- No backpressure on the response.
- Address bits above the word index are passed through; wrap is the memory's responsibility unless the bounds check is compiled in.
- Reset mid-operation: the request is dropped with no response. If reset asserts before the WRITE cycle's rising edge, memory is unmodified.

Optional Feature:
- Macro LSU_BOUNDS_CHECK_EN.
- Defined: a word index >= MEM_WORDS is treated as an error (1-cycle err response, no memory access), checked in IDLE alongside alignment.
- Undefined: no range check; mem_addr is forwarded as computed.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants (F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101).
  - The state enum (IDLE, READ, CAPTURE, MERGE, WRITE).
  - Lane-width constants.
- Sub-module lsu_align: combinational.
  - Load path: mem_rdata + addr[1:0] + funct3 -> extended data.
  - Store path: old word + wdata + addr[1:0] + funct3 -> merged word.
- The FSM stays in load_store_unit.

Test Plan (data memory preloaded word i = i):
- SW 0x28 wdata 0xDEADBEEF then LW 0x28: SW resp at cycle 2 with mem_we once at word 10; LW resp at cycle 3, rdata 0xDEADBEEF, err 0.
- After SW 0x28 = 0x80F07F01:
  - LB 0x28 -> 0x00000001
  - LB 0x2B -> 0xFFFFFF80
  - LBU 0x2B -> 0x00000080
  - LH 0x2A -> 0xFFFF80F0
  - LHU 0x2A -> 0x000080F0
- Word 10 = 0xDEADBEEF, SB 0x29 wdata 0x123456AB: memory word becomes 0xDEADABEF; exactly one mem_re then one mem_we; resp at cycle 4. SH 0x2A wdata 0x1234 on the result gives 0x1234ABEF.
- LW 0x2A, LH 0x29, load funct3 011: each gives resp_err=1 at cycle 1, rdata 0, mem_re=mem_we=0 throughout.
- SH 0x2A issued, rst_n pulsed low during MERGE: word 10 unchanged, no resp_valid, req_ready=1 after release, next LW 0x28 works.
- With LSU_BOUNDS_CHECK_EN, LW 0x400: err=1, no memory access. Without it: mem_re with mem_addr=256.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, lane widths,
// FSM state type and the request legality check.
package lsu_pkg;

  localparam int BYTE_W    = 8;
  localparam int HALF_W    = 16;
  localparam int WORD_W    = 32;
  localparam int NUM_LANES = WORD_W / BYTE_W;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    MERGE   = 3'd3,
    WRITE   = 3'd4
  } lsuState_e;

  // Illegal funct3 or misaligned address for the given direction.
  function automatic logic accessErr(input logic we, input logic [2:0] f3,
                                     input logic [1:0] lo);
    logic err;
    err = 1'b1;
    if (we) begin
      case (f3)
        F3_B:    err = 1'b0;
        F3_H:    err = lo[0];
        F3_W:    err = |lo;
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = lo[0];
        F3_W:        err = |lo;
        default:     err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response and data-memory signals of the load/store unit.
// slave = the unit itself; master = pipeline plus memory environment.
interface load_store_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_re;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wdata, mem_re, mem_we
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_addr, mem_wdata, mem_re, mem_we
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: load lane extraction with sign/zero extension and
// sub-word store merge into the old memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [WORD_W-1:0] memWord,
  input  logic [HALF_W-1:0] wdata,
  input  logic [1:0]        addrLo,
  input  logic [2:0]        funct3,
  output logic [WORD_W-1:0] loadData,
  output logic [WORD_W-1:0] mergedWord
);

  logic [NUM_LANES-1:0][BYTE_W-1:0] oldLanes;
  logic [NUM_LANES-1:0][BYTE_W-1:0] newLanes;
  logic [NUM_LANES-1:0]             laneEn;
  logic [BYTE_W-1:0]                byteSel;
  logic [HALF_W-1:0]                halfSel;

  assign oldLanes   = memWord;
  assign mergedWord = newLanes;
  assign byteSel    = oldLanes[addrLo];
  assign halfSel    = {oldLanes[{addrLo[1], 1'b1}], oldLanes[{addrLo[1], 1'b0}]};

  always_comb begin
    loadData = memWord;
    case (funct3)
      F3_B:    loadData = {{(WORD_W-BYTE_W){byteSel[BYTE_W-1]}}, byteSel};
      F3_BU:   loadData = {{(WORD_W-BYTE_W){1'b0}}, byteSel};
      F3_H:    loadData = {{(WORD_W-HALF_W){halfSel[HALF_W-1]}}, halfSel};
      F3_HU:   loadData = {{(WORD_W-HALF_W){1'b0}}, halfSel};
      default: loadData = memWord;
    endcase
  end

  // A halfword store drives lane pair {addr[1],x}; odd lanes take the upper store byte.
  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    localparam logic [1:0] LANE = 2'(i);
    assign laneEn[i]   = (funct3 == F3_B) ? (addrLo == LANE)
                                          : ((funct3 == F3_H) && (addrLo[1] == LANE[1]));
    assign newLanes[i] = !laneEn[i]       ? oldLanes[i]
                       : (funct3 == F3_H) ? wdata[BYTE_W*(i%2) +: BYTE_W]
                                          : wdata[BYTE_W-1:0];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a word-addressed data memory.
// Optional word-index range check: define LSU_BOUNDS_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  load_store_unit_if.slave       bus
);

  if (MEM_WORDS <= 0 || ADDR_W <= 2) begin : gBadCfg
    $error("load_store_unit: MEM_WORDS must be positive and ADDR_W above 2");
  end

  lsuState_e         state, nextState;
  logic              reqWe;
  logic [2:0]        reqF3;
  logic [ADDR_W-1:0] reqAddr;
  logic [HALF_W-1:0] reqWdata;
  logic [WORD_W-1:0] mergeReg;
  logic [WORD_W-1:0] loadData;
  logic [WORD_W-1:0] mergedWord;
  logic              accept;
  logic              acceptErr;
  logic              outOfRange;

`ifdef LSU_BOUNDS_CHECK_EN
  assign outOfRange = {2'b00, bus.req_addr[ADDR_W-1:2]} >= ADDR_W'(MEM_WORDS);
`else
  assign outOfRange = 1'b0;
`endif

  assign accept    = bus.req_valid && (state == IDLE);
  assign acceptErr = accessErr(bus.req_we, bus.req_funct3, bus.req_addr[1:0]) || outOfRange;

  // Memory side is purely a function of state and the captured request.
  assign bus.req_ready = (state == IDLE);
  assign bus.mem_re    = (state == READ);
  assign bus.mem_we    = (state == WRITE);
  assign bus.mem_addr  = {2'b00, reqAddr[ADDR_W-1:2]};
  assign bus.mem_wdata = mergeReg;

  lsu_align uAlign (
    .memWord    (bus.mem_rdata),
    .wdata      (reqWdata),
    .addrLo     (reqAddr[1:0]),
    .funct3     (reqF3),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept && !acceptErr)
                 nextState = (bus.req_we && bus.req_funct3 == F3_W) ? WRITE : READ;
      READ:    nextState = reqWe ? MERGE : CAPTURE;
      CAPTURE: nextState = IDLE;
      MERGE:   nextState = WRITE;
      WRITE:   nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Response and request/merge registers; responses are single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqWe           <= 1'b0;
      reqF3           <= '0;
      reqAddr         <= '0;
      reqWdata        <= '0;
      mergeReg        <= '0;
      bus.resp_valid  <= 1'b0;
      bus.resp_err    <= 1'b0;
      bus.resp_rdata  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      case (state)
        IDLE: if (accept) begin
          reqWe    <= bus.req_we;
          reqF3    <= bus.req_funct3;
          reqAddr  <= bus.req_addr;
          reqWdata <= bus.req_wdata[HALF_W-1:0];
          if (acceptErr) begin
            bus.resp_valid <= 1'b1;
            bus.resp_err   <= 1'b1;
          end else if (bus.req_we && bus.req_funct3 == F3_W) begin
            mergeReg <= bus.req_wdata;
          end
        end
        CAPTURE: begin
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= loadData;
        end
        MERGE:   mergeReg <= mergedWord;
        WRITE:   bus.resp_valid <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a registered-read word memory
// preloaded with word i = i.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(ADDR_W)) bus ();

  load_store_unit #(.ADDR_W(ADDR_W), .MEM_WORDS(256)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [31:0] mem [256];
  logic [31:0] rdq;
  logic        loaded = 1'b0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
      rdq    <= '0;
      loaded <= 1'b1;
    end else begin
      if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      if (bus.mem_re) rdq <= mem[bus.mem_addr[7:0]];
    end
  end
  assign bus.mem_rdata = rdq;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          nRe;
    int          nWe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat, input logic err,
                              input logic [31:0] rdata, input int nRe, input int nWe);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.lat = lat;
    v.err = err; v.rdata = rdata; v.nRe = nRe; v.nWe = nWe;
    return v;
  endfunction

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic runVec(input vec_t v, input string tag);
    int lat, nRe, nWe, busy;
    logic [31:0] rd, accAddr;
    logic err, got;
    lat = -1; nRe = 0; nWe = 0; busy = 0; rd = '0; err = 1'b0; got = 1'b0; accAddr = '0;
    check({tag, " ready_at_issue"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (bus.mem_re) begin nRe++; accAddr = bus.mem_addr; end
      if (bus.mem_we) begin nWe++; accAddr = bus.mem_addr; end
      if (bus.mem_re && bus.mem_we) check({tag, " re_we_overlap"}, 32'd1, 32'd0);
      if (!bus.req_ready) busy++;
      if (bus.resp_valid) begin
        lat = c; rd = bus.resp_rdata; err = bus.resp_err; got = 1'b1;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " err"}, 32'(err), 32'(v.err));
    check({tag, " rdata"}, rd, v.rdata);
    check({tag, " n_mem_re"}, 32'(nRe), 32'(v.nRe));
    check({tag, " n_mem_we"}, 32'(nWe), 32'(v.nWe));
    check({tag, " busy_cycles"}, 32'(busy), 32'(v.lat - 1));
    if (v.nRe + v.nWe > 0) check({tag, " mem_addr"}, accAddr, v.addr >> 2);
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    vecs.push_back(mk(1, F3_W,  32'h28, 32'hDEADBEEF, 2, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, F3_W,  32'h28, 32'h0,        3, 0, 32'hDEADBEEF, 1, 0));
    vecs.push_back(mk(1, F3_W,  32'h28, 32'h80F07F01, 2, 0, 32'h0,        0, 1));
    vecs.push_back(mk(0, F3_B,  32'h28, 32'h0,        3, 0, 32'h00000001, 1, 0));
    vecs.push_back(mk(0, F3_B,  32'h2B, 32'h0,        3, 0, 32'hFFFFFF80, 1, 0));
    vecs.push_back(mk(0, F3_BU, 32'h2B, 32'h0,        3, 0, 32'h00000080, 1, 0));
    vecs.push_back(mk(0, F3_B,  32'h29, 32'h0,        3, 0, 32'h0000007F, 1, 0));
    vecs.push_back(mk(0, F3_H,  32'h2A, 32'h0,        3, 0, 32'hFFFF80F0, 1, 0));
    vecs.push_back(mk(0, F3_HU, 32'h2A, 32'h0,        3, 0, 32'h000080F0, 1, 0));
    vecs.push_back(mk(0, F3_H,  32'h28, 32'h0,        3, 0, 32'h00007F01, 1, 0));
    vecs.push_back(mk(1, F3_W,  32'h28, 32'hDEADBEEF, 2, 0, 32'h0,        0, 1));
    vecs.push_back(mk(1, F3_B,  32'h29, 32'h123456AB, 4, 0, 32'h0,        1, 1));
    vecs.push_back(mk(0, F3_W,  32'h28, 32'h0,        3, 0, 32'hDEADABEF, 1, 0));
    vecs.push_back(mk(1, F3_H,  32'h2A, 32'h00001234, 4, 0, 32'h0,        1, 1));
    vecs.push_back(mk(0, F3_W,  32'h28, 32'h0,        3, 0, 32'h1234ABEF, 1, 0));
    vecs.push_back(mk(0, F3_W,  32'h2A, 32'h0,        1, 1, 32'h0,        0, 0));
    vecs.push_back(mk(0, F3_H,  32'h29, 32'h0,        1, 1, 32'h0,        0, 0));
    vecs.push_back(mk(0, 3'b011, 32'h28, 32'h0,       1, 1, 32'h0,        0, 0));
    vecs.push_back(mk(1, F3_BU, 32'h28, 32'h0,        1, 1, 32'h0,        0, 0));
    vecs.push_back(mk(1, F3_H,  32'h2B, 32'hFFFF,     1, 1, 32'h0,        0, 0));
    vecs.push_back(mk(0, F3_W,  32'h28, 32'h0,        3, 0, 32'h1234ABEF, 1, 0));
    vecs.push_back(mk(0, F3_B,  32'h05, 32'h0,        3, 0, 32'h00000000, 1, 0));
    vecs.push_back(mk(0, F3_BU, 32'h04, 32'h0,        3, 0, 32'h00000001, 1, 0));
    vecs.push_back(mk(0, F3_W,  32'h3C, 32'h0,        3, 0, 32'h0000000F, 1, 0));
`ifdef LSU_BOUNDS_CHECK_EN
    vecs.push_back(mk(0, F3_W,  32'h400, 32'h0,       1, 1, 32'h0,        0, 0));
`else
    vecs.push_back(mk(0, F3_W,  32'h400, 32'h0,       3, 0, 32'h0,        1, 0));
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst req_ready",  32'(bus.req_ready),  32'd1);
    check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst resp_err",   32'(bus.resp_err),   32'd0);
    check("rst resp_rdata", bus.resp_rdata,      32'd0);
    check("rst mem_re",     32'(bus.mem_re),     32'd0);
    check("rst mem_we",     32'(bus.mem_we),     32'd0);
    check("rst mem_addr",   bus.mem_addr,        32'd0);
    check("rst mem_wdata",  bus.mem_wdata,       32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) runVec(vecs[i], $sformatf("v%0d", i));

    // Reset during MERGE of an SH: the store must be dropped silently.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_H;
    bus.req_addr   = 32'h2A;
    bus.req_wdata  = 32'h00005555;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("rstmid read_cycle mem_re", 32'(bus.mem_re), 32'd1);
    @(negedge clk);
    check("rstmid merge_cycle mem_we", 32'(bus.mem_we), 32'd0);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rstmid c%0d resp_valid", c), 32'(bus.resp_valid), 32'd0);
      check($sformatf("rstmid c%0d mem_we", c),     32'(bus.mem_we),     32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid ready_after", 32'(bus.req_ready), 32'd1);
    check("rstmid resp_valid_after", 32'(bus.resp_valid), 32'd0);
    check("rstmid word10", mem[10], 32'h1234ABEF);
    runVec(mk(0, F3_W, 32'h28, 32'h0, 3, 0, 32'h1234ABEF, 1, 0), "post_rst_lw");

    @(negedge clk);
    check("final resp_valid_single", 32'(bus.resp_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
